// File: rtl/fifo_serial_tx_pkg.sv
// Shared types, default geometry and sizing helpers for the FIFO serial transmitter.
package fifo_serial_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} tx_state_e;

  localparam int DEF_DATA_WIDTH   = 66;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_GAP_BITS     = 2;
  localparam int DEF_CNT_W        = 16;

  // Counter width that stays at least 1 bit for tiny ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Cycles from one pop to the next when words are streamed back to back.
  function automatic int frame_cycles(input int dw, input int cpb, input int gap);
    return 1 + (1 + dw + gap) * cpb;
  endfunction

  localparam int PHASE_W      = width_of(DEF_CLKS_PER_BIT);
  localparam int BIT_W        = width_of(DEF_DATA_WIDTH);
  localparam int GAP_W        = width_of(DEF_GAP_BITS + 1);
  localparam int FRAME_CYCLES = frame_cycles(DEF_DATA_WIDTH, DEF_CLKS_PER_BIT, DEF_GAP_BITS);

endpackage

// File: rtl/fifo_serial_tx_bitclk.sv
// Bit-period phase counter and forwarded serial clock.
module fifo_serial_tx_bitclk
  import fifo_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic phase_last,
  output logic bitclk
);

  localparam int PH_W = width_of(CLKS_PER_BIT);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLKS_PER_BIT / 2);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            bitclk_q, bitclk_d;

  assign phase_last = run && (phase_q == PH_LAST);
  assign bitclk     = bitclk_q;

  // The clock flop follows the phase the counter is about to enter, so it
  // lines up with the registered data outputs.
  always_comb begin
    phase_d = '0;
    if (run && !phase_last) phase_d = phase_q + 1'b1;
    bitclk_d = (phase_d >= PH_HIGH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q  <= '0;
      bitclk_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      bitclk_q <= bitclk_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a show-ahead FIFO and sends each as a framed MSB-first
// serial stream with a forwarded bit clock.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int GAP_BITS     = DEF_GAP_BITS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rden_o,
  output logic                  ser_data_o,
  output logic                  ser_clk_o,
  output logic                  ser_frame_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      words_sent_o
);

  localparam int BIT_CNT_W = width_of(DATA_WIDTH);
  localparam int GAP_CNT_W = width_of(GAP_BITS + 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [GAP_CNT_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ser_data_q, ser_data_d;
  logic                  ser_frame_q, ser_frame_d;
  logic                  busy_q;
  logic                  pop;
  logic                  phase_last;
  logic                  bitclk;

  fifo_serial_tx_bitclk #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bitclk (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (state_q != IDLE),
    .phase_last (phase_last),
    .bitclk     (bitclk)
  );

  assign fifo_rden_o  = pop;
  assign ser_data_o   = ser_data_q;
  assign ser_clk_o    = bitclk;
  assign ser_frame_o  = ser_frame_q;
  assign busy_o       = busy_q;
  assign words_sent_o = cnt_q;

  // Serial outputs are computed for the state being entered, so they only
  // move on bit-period boundaries.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    ser_data_d  = ser_data_q;
    ser_frame_d = ser_frame_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        pop = reset_n & enable_i & ~fifo_empty_i;
        if (pop) begin
          shift_d     = fifo_rdata_i;
          state_d     = START;
          ser_data_d  = 1'b1;
          ser_frame_d = 1'b1;
        end
      end
      START: begin
        if (phase_last) begin
          state_d    = DATA;
          bit_d      = BIT_CNT_W'(DATA_WIDTH - 1);
          ser_data_d = shift_q[DATA_WIDTH-1];
        end
      end
      DATA: begin
        if (phase_last) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_q == '0) begin
            state_d     = GAP;
            gap_d       = GAP_CNT_W'(GAP_BITS - 1);
            ser_data_d  = 1'b0;
            ser_frame_d = 1'b0;
          end else begin
            bit_d      = bit_q - 1'b1;
            ser_data_d = shift_q[DATA_WIDTH-2];
          end
        end
      end
      GAP: begin
        if (phase_last) begin
          if (gap_q == '0) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      ser_data_q  <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      ser_data_q  <= ser_data_d;
      ser_frame_q <= ser_frame_d;
      busy_q      <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Drain side for the sync show-ahead FIFO used in the measurement path: pops one DATA_WIDTH word whenever the FIFO is non-empty and enabled, then transmits it off-chip as a framed, MSB-first serial stream with a forwarded bit clock.
- Connects directly to the FIFO's `empty_o`, `rdata_o` and `rden_i` pins.
- Read data is combinational from the FIFO read pointer and is valid whenever `empty_o` is 0.

Parameters:
- DATA_WIDTH, 66, width of a FIFO word and of the serial payload.
- CLKS_PER_BIT, 4, clk cycles per serial bit; must be even and ≥2.
- GAP_BITS, 2, idle bit periods after each frame; must be ≥1.
- CNT_W, 16, width of the sent-word counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- enable_i  in  1  permit new pops; the word in flight always completes
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rdata_i  in  DATA_WIDTH  FIFO head word (show-ahead)
- fifo_rden_o  out  1  FIFO pop strobe, one cycle per word
- ser_data_o  out  1  serial data, MSB first
- ser_clk_o  out  1  forwarded bit clock; receiver samples on its rising edge
- ser_frame_o  out  1  high during start bit and payload bits
- busy_o  out  1  high in any state other than IDLE
- words_sent_o  out  CNT_W  count of completed frames, wraps

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Reset values:
  - FSM = IDLE.
  - ser_data_o = ser_clk_o = ser_frame_o = 0; busy_o = 0; words_sent_o = 0.
  - Shift register and counters = 0.
  - fifo_rden_o = 0 while reset_n is 0.
- FSM states: IDLE, START, DATA, GAP.
- IDLE:
  - fifo_rden_o = enable_i & ~fifo_empty_i. This is combinational and asserted only in IDLE.
  - On a pop cycle, fifo_rdata_i is loaded into the shift register at the same edge and the FSM goes to START.
  - Otherwise the FSM stays in IDLE.
- START:
  - 1 bit period: ser_data_o = 1, ser_frame_o = 1.
  - Then go to DATA with bit index = DATA_WIDTH-1.
- DATA:
  - DATA_WIDTH bit periods: ser_data_o = shift-register MSB; shift left by 1 at the end of each period; ser_frame_o = 1.
  - After the last bit (index 0), go to GAP.
- GAP:
  - GAP_BITS bit periods: ser_data_o = 0, ser_frame_o = 0.
  - At the end of the last period, increment words_sent_o (mod 2^CNT_W) and go to IDLE.
- Bit period:
  - A phase counter runs 0..CLKS_PER_BIT-1 in START, DATA and GAP, and is held at 0 in IDLE.
  - ser_clk_o = 1 for phases ≥ CLKS_PER_BIT/2, else 0.
  - ser_data_o and ser_frame_o change only at phase 0, so data is stable for half a period on each side of the ser_clk_o rising edge.
  - ser_clk_o = 0 in IDLE.
- Output registration: ser_* outputs and busy_o are registered and take their new-state values on the same edge as the state change. The first START cycle is the cycle after the pop cycle.
- Throughput:
  - IDLE lasts at least 1 cycle between frames.
  - Back-to-back words: pops are 1 + (1+DATA_WIDTH+GAP_BITS)*CLKS_PER_BIT cycles apart.
- enable_i dropped mid-frame: the frame and its gap complete, then the FSM holds in IDLE with no pop.
- fifo_empty_i is ignored outside IDLE. fifo_rdata_i is sampled only on the pop cycle.
- Reset mid-frame: all state is cleared on the next edge. The popped word is discarded and not retransmitted. ser_frame_o drops to 0 in the first reset cycle.
- No pop is ever issued when fifo_empty_i = 1, so the FIFO cannot underflow.

Decomposition:
- Package fifo_serial_tx_pkg holds:
  - the state enum (IDLE, START, DATA, GAP);
  - localparams PHASE_W = clog2(CLKS_PER_BIT), BIT_W = clog2(DATA_WIDTH), GAP_W = clog2(GAP_BITS+1);
  - a FRAME_CYCLES constant.
- One sub-module, fifo_serial_tx_bitclk:
  - Contains the phase counter and ser_clk_o generation.
  - Inputs: run, reset_n.
  - Outputs: phase_last (end of bit period), bitclk.
- The FSM, shift register and counters stay in the top module.

Test Plan (DATA_WIDTH=66, CLKS_PER_BIT=4, GAP_BITS=2; frame = 277 cycles):
- Single word 66'h2_DEAD_BEEF_0123_4567 written into an empty FIFO:
  - fifo_rden_o pulses once.
  - The receiver model captures start=1, then the 66 bits MSB-first equal to the written word.
  - ser_frame_o is high for 268 cycles.
  - words_sent_o = 1.
- Three words preloaded: pops occur exactly 277 cycles apart; the FIFO goes empty after the third pop; words_sent_o = 3; no rden while empty.
- enable_i = 0 with the FIFO holding 2 words:
  - No pop and busy_o = 0 for 500 cycles.
  - Raising enable_i gives a pop on the next cycle.
  - Dropping enable_i mid-frame 1 completes frame 1 only.
- reset_n low for 1 cycle at DATA bit 30:
  - The next cycle shows ser_frame_o = 0, ser_clk_o = 0, words_sent_o = 0.
  - After release, the next FIFO word is sent intact.
- Set words_sent_o near wrap by sending 2^CNT_W+1 words (reduced CNT_W=4 build, 17 words): the counter reads 1.
- Clock/data alignment check over a full frame: ser_data_o never changes while ser_clk_o = 1, and each ser_clk_o rising edge is 2 cycles after a data change.
